// File: rtl/grid_wb_commit_queue.sv
// Commit queue behind the grid writeback selector: buffers whole writeback bundles and
// serialises them, one register write per beat, onto a valid/ack writeback interface.
module grid_wb_commit_queue #(
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ID_W            = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]      output_data,
  input  logic                                      wb_committing,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]           rd_addrs,
  input  logic [NUM_WRITE_PORTS-1:0]                rd_en,
  input  logic [ID_W-1:0]                           instr_id,
  input  logic                                      flush,
  output logic                                      commit_accept,
  output logic                                      wb_valid,
  output logic [4:0]                                wb_rd,
  output logic [XLEN-1:0]                           wb_data,
  output logic [ID_W-1:0]                           wb_id,
  output logic                                      wb_last,
  input  logic                                      wb_ack,
  output logic [$clog2(DEPTH+1)-1:0]                queue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  typedef enum logic {StIdle, StSend} state_e;

  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] mem_data_q [DEPTH];
  logic [NUM_WRITE_PORTS-1:0][4:0]      mem_rd_q   [DEPTH];
  logic [NUM_WRITE_PORTS-1:0]           mem_en_q   [DEPTH];
  logic [ID_W-1:0]                      mem_id_q   [DEPTH];

  state_e          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [NUM_WRITE_PORTS-1:0] head_w, next_w, in_w;

  function automatic logic [NUM_WRITE_PORTS-1:0] writable(
    input logic [NUM_WRITE_PORTS-1:0]      en,
    input logic [NUM_WRITE_PORTS-1:0][4:0] rd
  );
    for (int i = 0; i < int'(NUM_WRITE_PORTS); i++) writable[i] = en[i] && (rd[i] != 5'd0);
  endfunction

  // Lowest writable port; 0 when none, which makes an empty bundle a single zero beat.
  function automatic logic [PW-1:0] first_idx(input logic [NUM_WRITE_PORTS-1:0] m);
    first_idx = '0;
    for (int i = int'(NUM_WRITE_PORTS) - 1; i >= 0; i--) if (m[i]) first_idx = PW'(i);
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [NUM_WRITE_PORTS-1:0] m,
                                             input logic [PW-1:0] p);
    next_idx = p;
    for (int i = int'(NUM_WRITE_PORTS) - 1; i >= 0; i--)
      if (m[i] && (PW'(i) > p)) next_idx = PW'(i);
  endfunction

  function automatic logic any_above(input logic [NUM_WRITE_PORTS-1:0] m,
                                     input logic [PW-1:0] p);
    any_above = 1'b0;
    for (int i = 0; i < int'(NUM_WRITE_PORTS); i++) if (m[i] && (PW'(i) > p)) any_above = 1'b1;
  endfunction

  assign rd_next       = rd_ptr_q + AW'(1);
  assign head_w        = writable(mem_en_q[rd_ptr_q], mem_rd_q[rd_ptr_q]);
  assign next_w        = writable(mem_en_q[rd_next], mem_rd_q[rd_next]);
  assign in_w          = writable(rd_en, rd_addrs);
  assign commit_accept = count_q < CW'(DEPTH);
  assign queue_count   = count_q;

  // Beat outputs decoded from registered state only; zero while idle.
  always_comb begin
    wb_valid = (state_q == StSend);
    wb_rd    = '0;
    wb_data  = '0;
    wb_id    = '0;
    wb_last  = 1'b0;
    if (wb_valid) begin
      wb_id   = mem_id_q[rd_ptr_q];
      wb_last = !any_above(head_w, p_q);
      if (head_w[p_q]) begin
        wb_rd   = mem_rd_q[rd_ptr_q][p_q];
        wb_data = mem_data_q[rd_ptr_q][p_q];
      end
    end
  end

  // Next-state: pointers, count and serialiser port index.
  always_comb begin
    push     = wb_committing && commit_accept && !flush;
    pop      = wb_valid && wb_ack && wb_last && !flush;
    state_d  = state_q;
    p_d      = p_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      state_d  = StIdle;
      p_d      = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_next;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      unique case (state_q)
        StIdle: begin
          // Idle implies empty, so an incoming bundle becomes the head directly.
          if (push) begin
            state_d = StSend;
            p_d     = first_idx(in_w);
          end
        end
        StSend: begin
          if (wb_ack && !wb_last) begin
            p_d = next_idx(head_w, p_q);
          end else if (pop) begin
            if (count_q > CW'(1)) begin
              p_d = first_idx(next_w);
            end else if (push) begin
              p_d = first_idx(in_w);
            end else begin
              state_d = StIdle;
              p_d     = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      p_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bundle storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= output_data;
      mem_rd_q[wr_ptr_q]   <= rd_addrs;
      mem_en_q[wr_ptr_q]   <= rd_en;
      mem_id_q[wr_ptr_q]   <= instr_id;
    end
  end

endmodule

// File: tb/tb_grid_wb_commit_queue.sv
// Self-checking bench: bundle-level queue model plus directed literal checks.
module tb_grid_wb_commit_queue;
  localparam int NWP = 2, XLEN = 32, DEPTH = 4, ID_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NWP-1:0][XLEN-1:0] output_data;
  logic wb_committing, flush, wb_ack;
  logic [NWP-1:0][4:0] rd_addrs;
  logic [NWP-1:0] rd_en;
  logic [ID_W-1:0] instr_id;
  logic commit_accept, wb_valid, wb_last;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [ID_W-1:0] wb_id;
  logic [$clog2(DEPTH+1)-1:0] queue_count;

  always #5 clk = ~clk;

  grid_wb_commit_queue #(.NUM_WRITE_PORTS(NWP), .XLEN(XLEN), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .output_data(output_data), .wb_committing(wb_committing),
    .rd_addrs(rd_addrs), .rd_en(rd_en), .instr_id(instr_id), .flush(flush),
    .commit_accept(commit_accept), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_id(wb_id), .wb_last(wb_last), .wb_ack(wb_ack), .queue_count(queue_count)
  );

  typedef struct packed {
    logic [NWP-1:0][XLEN-1:0] data;
    logic [NWP-1:0][4:0]      rd;
    logic [NWP-1:0]           en;
    logic [ID_W-1:0]          id;
  } bundle_t;

  bundle_t q[$];
  int      hidx;
  bit      pushed_last;
  int      n_checks = 0;
  int      n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beats of a bundle are its writable ports in ascending order, or one zero beat if none.
  function automatic int beat_count(input bundle_t b);
    int n = 0;
    for (int i = 0; i < NWP; i++) if (b.en[i] && b.rd[i] != 0) n++;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int beat_port(input bundle_t b, input int k);
    int n = 0;
    for (int i = 0; i < NWP; i++)
      if (b.en[i] && b.rd[i] != 0) begin
        if (n == k) return i;
        n++;
      end
    return -1;
  endfunction

  task automatic check_model();
    bundle_t b;
    int k;
    chk("queue_count", 64'(queue_count), 64'(q.size()));
    chk("commit_accept", 64'(commit_accept), 64'(q.size() < DEPTH));
    chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      b = q[0];
      k = beat_port(b, hidx);
      chk("wb_rd", 64'(wb_rd), (k < 0) ? 64'd0 : 64'(b.rd[k]));
      chk("wb_data", 64'(wb_data), (k < 0) ? 64'd0 : 64'(b.data[k]));
      chk("wb_id", 64'(wb_id), 64'(b.id));
      chk("wb_last", 64'(wb_last), 64'(hidx == beat_count(b) - 1));
    end
  endtask

  task automatic model_update();
    bundle_t nb;
    bit push, pop;
    pushed_last = 1'b0;
    if (rst || flush) begin
      q.delete();
      hidx = 0;
      return;
    end
    push = wb_committing && (q.size() < DEPTH);
    pop  = (q.size() != 0) && wb_ack && (hidx == beat_count(q[0]) - 1);
    if (pop) begin
      void'(q.pop_front());
      hidx = 0;
    end else if (q.size() != 0 && wb_ack) begin
      hidx++;
    end
    if (push) begin
      nb.data = output_data; nb.rd = rd_addrs; nb.en = rd_en; nb.id = instr_id;
      q.push_back(nb);
      pushed_last = 1'b1;
    end
  endtask

  // Advance one clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_bundle(input logic [NWP-1:0][4:0] rd, input logic [NWP-1:0] en,
                            input logic [NWP-1:0][XLEN-1:0] d, input logic [ID_W-1:0] id);
    wb_committing = 1'b1; rd_addrs = rd; rd_en = en; output_data = d; instr_id = id;
  endtask

  task automatic rand_bundle();
    logic [NWP-1:0][4:0] rd;
    logic [NWP-1:0][XLEN-1:0] d;
    for (int i = 0; i < NWP; i++) begin
      rd[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d[i]  = $urandom;
    end
    set_bundle(rd, NWP'($urandom_range(0, 3)), d, ID_W'($urandom_range(0, 7)));
  endtask

  task automatic drain();
    int guard = 0;
    wb_committing = 1'b0; wb_ack = 1'b1; flush = 1'b0;
    while (q.size() != 0 && guard < 40) begin
      step();
      guard++;
    end
    chk("drain_bound", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int pa, pc;
    logic [4:0] held_rd;
    rst = 1'b1; wb_committing = 1'b0; flush = 1'b0; wb_ack = 1'b0;
    rd_addrs = '0; rd_en = '0; output_data = '0; instr_id = '0;
    q.delete(); hidx = 0;
    @(negedge clk);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_last", 64'(wb_last), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    chk("rst_data", 64'(wb_data), 64'd0);
    chk("rst_id", 64'(wb_id), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_accept", 64'(commit_accept), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single bundle, both ports writable, ack held high.
    wb_ack = 1'b1;
    set_bundle({5'd9, 5'd5}, 2'b11, {32'h22, 32'h11}, 3'd3);
    step();
    wb_committing = 1'b0;
    chk("t1_b0_valid", 64'(wb_valid), 64'd1);
    chk("t1_b0_rd", 64'(wb_rd), 64'd5);
    chk("t1_b0_data", 64'(wb_data), 64'h11);
    chk("t1_b0_last", 64'(wb_last), 64'd0);
    chk("t1_count", 64'(queue_count), 64'd1);
    step();
    chk("t1_b1_rd", 64'(wb_rd), 64'd9);
    chk("t1_b1_data", 64'(wb_data), 64'h22);
    chk("t1_b1_last", 64'(wb_last), 64'd1);
    chk("t1_b1_id", 64'(wb_id), 64'd3);
    step();
    chk("t1_empty", 64'(queue_count), 64'd0);

    // Port with rd=0 is skipped; an all-disabled bundle yields one zero beat.
    set_bundle({5'd7, 5'd0}, 2'b11, {32'hBEEF, 32'hDEAD}, 3'd2);
    step();
    wb_committing = 1'b0;
    chk("t2_rd", 64'(wb_rd), 64'd7);
    chk("t2_data", 64'(wb_data), 64'hBEEF);
    chk("t2_last", 64'(wb_last), 64'd1);
    step();
    set_bundle({5'd4, 5'd3}, 2'b00, {32'h1, 32'h2}, 3'd5);
    step();
    wb_committing = 1'b0;
    chk("t2e_valid", 64'(wb_valid), 64'd1);
    chk("t2e_rd", 64'(wb_rd), 64'd0);
    chk("t2e_data", 64'(wb_data), 64'd0);
    chk("t2e_last", 64'(wb_last), 64'd1);
    chk("t2e_id", 64'(wb_id), 64'd5);
    drain();

    // Fill to capacity without acks; a fifth bundle must wait.
    wb_ack = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (!wb_committing || pushed_last) rand_bundle();
      step();
    end
    chk("t3_full_count", 64'(queue_count), 64'd4);
    chk("t3_full_accept", 64'(commit_accept), 64'd0);
    wb_ack = 1'b1;
    for (int i = 0; i < beat_count(q[0]); i++) step();
    chk("t3_after_pop_count", 64'(queue_count), 64'd3);
    chk("t3_after_pop_accept", 64'(commit_accept), 64'd1);
    drain();

    // Backpressure for 10 cycles mid-bundle.
    wb_ack = 1'b0;
    set_bundle({5'd12, 5'd11}, 2'b11, {32'hB2, 32'hA1}, 3'd6);
    step();
    wb_committing = 1'b0;
    held_rd = wb_rd;
    for (int i = 0; i < 10; i++) step();
    chk("t4_hold_rd", 64'(wb_rd), 64'(held_rd));
    chk("t4_hold_data", 64'(wb_data), 64'hA1);
    drain();

    // Flush with 3 queued plus simultaneous push and ack.
    wb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bundle();
      step();
    end
    rand_bundle(); wb_ack = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; wb_committing = 1'b0;
    chk("t5_flush_count", 64'(queue_count), 64'd0);
    chk("t5_flush_valid", 64'(wb_valid), 64'd0);
    step();
    chk("t5_dropped", 64'(queue_count), 64'd0);

    // Randomised traffic with varying ack/commit pressure.
    for (int ph = 0; ph < 6; ph++) begin
      pa = (ph % 3 == 0) ? 100 : (ph % 3 == 1) ? 30 : 70;
      pc = (ph < 3) ? 80 : 40;
      for (int c = 0; c < 150; c++) begin
        if (!wb_committing || pushed_last) begin
          if ($urandom_range(0, 99) < pc) rand_bundle();
          else wb_committing = 1'b0;
        end
        wb_ack = ($urandom_range(0, 99) < pa);
        flush  = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    flush = 1'b0;

    // Asynchronous reset mid-beat.
    wb_ack = 1'b0;
    set_bundle({5'd21, 5'd20}, 2'b11, {32'h7, 32'h6}, 3'd1);
    step();
    wb_committing = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_valid", 64'(wb_valid), 64'd0);
    chk("t6_arst_rd", 64'(wb_rd), 64'd0);
    chk("t6_arst_count", 64'(queue_count), 64'd0);
    chk("t6_arst_accept", 64'(commit_accept), 64'd1);
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
